prog_load_ctrl: RTL

UART program-loading controller and memory write-port arbiter for the single-cycle CPU.
- While `load_req` is high, it holds the CPU in reset and takes the instruction-memory and data-memory write ports.
- It consumes a framed byte stream from the UART receiver, packs the bytes into 32-bit words and writes them into the selected memory.
- When `load_req` is low, it passes the CPU's data-memory write port straight through.
- It sits between the CPU core, dmemory32/instruction RAM and the UART receiver.

---
 rtl/prog_load_pkg.sv | 17 +
 rtl/prog_load_ctrl_if.sv | 33 +++
 rtl/word_packer.sv | 30 +++
 rtl/prog_load_ctrl.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prog_load_pkg.sv
// Shared types and constants for the UART program loader.
package prog_load_pkg;

  typedef enum logic [2:0] {
    StRun,
    StHdr,
    StData,
    StCsum,
    StErr
  } state_e;

  localparam logic [7:0] TGT_IMEM = 8'h00;
  localparam logic [7:0] TGT_DMEM = 8'h01;

  localparam int unsigned HDR_LEN = 4;

endpackage

// File: rtl/prog_load_ctrl_if.sv
// Bus bundle between the loader, the CPU data port, the UART receiver and the memories.
interface prog_load_ctrl_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              load_req;
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              cpu_mem_write;
  logic [ADDR_W-1:0] cpu_mem_addr;
  logic [31:0]       cpu_mem_wdata;
  logic              dmem_write;
  logic              imem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              load_busy;
  logic              load_err;
  logic [7:0]        frames_ok;

  // Environment side: switch, UART receiver, CPU core and memories.
  modport master (
    output load_req, rx_valid, rx_data, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    input  dmem_write, imem_write, mem_addr, mem_wdata, cpu_hold, load_busy, load_err,
           frames_ok
  );

  // Loader side.
  modport slave (
    input  load_req, rx_valid, rx_data, cpu_mem_write, cpu_mem_addr, cpu_mem_wdata,
    output dmem_write, imem_write, mem_addr, mem_wdata, cpu_hold, load_busy, load_err,
           frames_ok
  );
endinterface

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words.
module word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_byte_valid,
  input  logic [7:0]  i_byte,
  output logic        o_word_valid,
  output logic [31:0] o_word
);

  logic [1:0]  r_cnt;
  logic [23:0] r_sr;

  // Shift earlier bytes down so the first byte ends up in bits [7:0].
  always_ff @(posedge clock) begin
    if (reset || i_clear) begin
      r_cnt <= 2'd0;
      r_sr  <= 24'd0;
    end else if (i_byte_valid) begin
      r_cnt <= r_cnt + 2'd1;
      r_sr  <= {i_byte, r_sr[23:8]};
    end
  end

  // The fourth byte completes the word on the cycle it arrives.
  assign o_word_valid = i_byte_valid && (r_cnt == 2'd3);
  assign o_word       = {i_byte, r_sr};

endmodule

// File: rtl/prog_load_ctrl.sv
// UART program loader: frame FSM, memory write generation and CPU write-port arbiter.
module prog_load_ctrl
  import prog_load_pkg::*;
#(
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned TIMEOUT = 2_000_000
) (
  input  logic             clock,
  input  logic             reset,
  prog_load_ctrl_if.slave  bus
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [32:0] N_MAX = 33'(1) << ADDR_W;

  state_e            r_state, w_state_next;
  logic [1:0]        r_hdr_cnt;
  logic [7:0]        r_target;
  logic [15:0]       r_n;
  logic [16:0]       r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_xor;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_err;
  logic [7:0]        r_frames;
  logic              r_imem_we, r_dmem_we;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;

  logic        w_rx, w_tmo_active, w_tmo_hit, w_hdr_last, w_last_word;
  logic        w_word_valid, w_set_err, w_frame_ok;
  logic [31:0] w_word;

  // Bytes arriving while load_req is low are discarded.
  assign w_rx         = bus.rx_valid && bus.load_req;
  assign w_tmo_active = (r_state == StHdr && r_hdr_cnt != 2'd0) ||
                        (r_state == StData) || (r_state == StCsum);
  assign w_tmo_hit    = w_tmo_active && !w_rx && (r_tmo == TMO_W'(TIMEOUT - 1));
  assign w_hdr_last   = (r_state == StHdr) && w_rx && (r_hdr_cnt == 2'(HDR_LEN - 1));
  assign w_last_word  = w_word_valid && (r_wcnt == ({1'b0, r_n} - 17'd1));

  word_packer u_packer (
    .clock        (clock),
    .reset        (reset),
    .i_clear      (r_state != StData),
    .i_byte_valid (w_rx && (r_state == StData)),
    .i_byte       (bus.rx_data),
    .o_word_valid (w_word_valid),
    .o_word       (w_word)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) r_state <= StRun;
    else       r_state <= w_state_next;
  end

  // Next state plus error and good-frame strobes; dropping load_req wins over everything.
  always_comb begin
    w_state_next = r_state;
    w_set_err    = 1'b0;
    w_frame_ok   = 1'b0;
    if (!bus.load_req) begin
      w_state_next = StRun;
      w_set_err    = w_tmo_active;
    end else begin
      unique case (r_state)
        StRun: w_state_next = StHdr;
        StHdr: begin
          if (w_hdr_last) begin
            if (r_target > TGT_DMEM || 33'(r_n) > N_MAX) w_state_next = StErr;
            else if (r_n == 16'd0)                       w_state_next = StCsum;
            else                                         w_state_next = StData;
          end else if (w_tmo_hit) begin
            w_state_next = StErr;
            w_set_err    = 1'b1;
          end
        end
        StData: begin
          if (w_last_word) begin
            w_state_next = StCsum;
          end else if (w_tmo_hit) begin
            w_state_next = StErr;
            w_set_err    = 1'b1;
          end
        end
        StCsum: begin
          if (w_rx) begin
            if (bus.rx_data == r_xor) begin
              w_state_next = StHdr;
              w_frame_ok   = 1'b1;
            end else begin
              w_state_next = StErr;
              w_set_err    = 1'b1;
            end
          end else if (w_tmo_hit) begin
            w_state_next = StErr;
            w_set_err    = 1'b1;
          end
        end
        StErr:   w_state_next = StErr;
        default: w_state_next = StRun;
      endcase
    end
  end

  // Sticky error flag (cleared on load entry) and good-frame counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err    <= 1'b0;
      r_frames <= 8'd0;
    end else begin
      if (r_state == StRun && bus.load_req) r_err <= 1'b0;
      else if (w_set_err)                   r_err <= 1'b1;
      if (w_frame_ok) r_frames <= r_frames + 8'd1;
    end
  end

  // Inter-byte timeout counter; idle in HDR until the first header byte.
  always_ff @(posedge clock) begin
    if (reset || !w_tmo_active || w_rx) r_tmo <= '0;
    else                                r_tmo <= r_tmo + 1'b1;
  end

  // Header capture and running XOR over header and payload bytes.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_hdr_cnt <= 2'd0;
      r_target  <= 8'd0;
      r_n       <= 16'd0;
      r_xor     <= 8'd0;
    end else begin
      if (r_state != StHdr) r_hdr_cnt <= 2'd0;
      else if (w_rx)        r_hdr_cnt <= r_hdr_cnt + 2'd1;
      if (w_rx && r_state == StHdr) begin
        case (r_hdr_cnt)
          2'd0: begin
            r_target <= bus.rx_data;
            r_xor    <= bus.rx_data;
          end
          2'd1: begin
            r_n[7:0] <= bus.rx_data;
            r_xor    <= r_xor ^ bus.rx_data;
          end
          2'd2: begin
            r_n[15:8] <= bus.rx_data;
            r_xor     <= r_xor ^ bus.rx_data;
          end
          default: r_xor <= r_xor ^ bus.rx_data;
        endcase
      end else if (w_rx && r_state == StData) begin
        r_xor <= r_xor ^ bus.rx_data;
      end
    end
  end

  // Word address and word count for the current frame.
  always_ff @(posedge clock) begin
    if (reset || w_hdr_last) begin
      r_addr <= '0;
      r_wcnt <= 17'd0;
    end else if (w_word_valid) begin
      r_addr <= r_addr + 1'b1;
      r_wcnt <= r_wcnt + 17'd1;
    end
  end

  // Registered one-cycle write pulse to the latched target memory.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_imem_we <= 1'b0;
      r_dmem_we <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= 32'd0;
    end else begin
      r_imem_we <= w_word_valid && (r_target == TGT_IMEM);
      r_dmem_we <= w_word_valid && (r_target == TGT_DMEM);
      if (w_word_valid) begin
        r_wr_addr <= r_addr;
        r_wr_data <= w_word;
      end
    end
  end

  // Arbiter: CPU pass-through in RUN, loader owns the write ports otherwise.
  always_comb begin
    bus.imem_write = 1'b0;
    bus.dmem_write = bus.cpu_mem_write;
    bus.mem_addr   = bus.cpu_mem_addr;
    bus.mem_wdata  = bus.cpu_mem_wdata;
    if (r_state != StRun) begin
      bus.imem_write = r_imem_we;
      bus.dmem_write = r_dmem_we;
      bus.mem_addr   = r_wr_addr;
      bus.mem_wdata  = r_wr_data;
    end
  end

  assign bus.cpu_hold  = (r_state != StRun);
  assign bus.load_busy = (r_state != StRun);
  assign bus.load_err  = r_err;
  assign bus.frames_ok = r_frames;

endmodule
